// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared definitions for the pipeline hazard controller: register-index width,
// interrupt vector, drain counter width and the interrupt-sequencing FSM states.
package pipe_ctrl_pkg;

  localparam int REG_ID_W    = 4;
  localparam int DRAIN_CNT_W = 4;   // holds DRAIN_CYCLES-1 for DRAIN_CYCLES in 1..15
  localparam int PERF_CNT_W  = 16;  // width of the optional performance counters

  localparam logic [31:0] IRQ_VECTOR = 32'h0000_0010;

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    DRAIN  = 2'd1,
    INJECT = 2'd2,
    ISR    = 2'd3
  } state_e;

endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// Pipeline <-> hazard controller signal bundle. The master side is the datapath,
// the slave side is the controller. Performance counter signals exist only when
// PIPE_HAZARD_PERF_EN is defined.
interface pipe_hazard_ctrl_if;
  import pipe_ctrl_pkg::*;

  logic [REG_ID_W-1:0] id_rs1;
  logic [REG_ID_W-1:0] id_rs2;
  logic                id_rs1_used;
  logic                id_rs2_used;
  logic [REG_ID_W-1:0] ex_reg_dst;
  logic                ex_reg_wr;
  logic                ex_load;
  logic                ex_redirect;
  logic                ex_returni;
  logic                mem_busy;
  logic                irq_req;

  logic pc_stall;
  logic stall_if_id;
  logic stall_id_ex;
  logic stall_ex_mem;
  logic flush_if_id;
  logic flush_id_ex;
  logic flush_mem_wb;
  logic irq_inject;
  logic irq_ack;
  logic in_isr;

`ifdef PIPE_HAZARD_PERF_EN
  logic                  perf_clr;
  logic [PERF_CNT_W-1:0] perf_stall_cnt;
  logic [PERF_CNT_W-1:0] perf_flush_cnt;
  logic [PERF_CNT_W-1:0] perf_irq_cnt;
`endif

  modport master (
    output id_rs1, id_rs2, id_rs1_used, id_rs2_used, ex_reg_dst, ex_reg_wr,
           ex_load, ex_redirect, ex_returni, mem_busy, irq_req,
`ifdef PIPE_HAZARD_PERF_EN
    output perf_clr,
    input  perf_stall_cnt, perf_flush_cnt, perf_irq_cnt,
`endif
    input  pc_stall, stall_if_id, stall_id_ex, stall_ex_mem, flush_if_id,
           flush_id_ex, flush_mem_wb, irq_inject, irq_ack, in_isr
  );

  modport slave (
    input  id_rs1, id_rs2, id_rs1_used, id_rs2_used, ex_reg_dst, ex_reg_wr,
           ex_load, ex_redirect, ex_returni, mem_busy, irq_req,
`ifdef PIPE_HAZARD_PERF_EN
    input  perf_clr,
    output perf_stall_cnt, perf_flush_cnt, perf_irq_cnt,
`endif
    output pc_stall, stall_if_id, stall_id_ex, stall_ex_mem, flush_if_id,
           flush_id_ex, flush_mem_wb, irq_inject, irq_ack, in_isr
  );

endinterface

// File: rtl/pipe_hazard_ctrl_load_use_detect.sv
// Combinational load-use compare: the load in EX targets a register the ID
// instruction actually reads. Register 0 is never a real destination.
module load_use_detect
  import pipe_ctrl_pkg::*;
(
  input  logic [REG_ID_W-1:0] i_id_rs1,
  input  logic [REG_ID_W-1:0] i_id_rs2,
  input  logic                i_id_rs1_used,
  input  logic                i_id_rs2_used,
  input  logic [REG_ID_W-1:0] i_ex_reg_dst,
  input  logic                i_ex_reg_wr,
  input  logic                i_ex_load,
  output logic                o_hazard
);

  logic w_dst_valid;
  logic w_rs1_hit;
  logic w_rs2_hit;

  assign w_dst_valid = i_ex_load & i_ex_reg_wr & (i_ex_reg_dst != {REG_ID_W{1'b0}});
  assign w_rs1_hit   = i_id_rs1_used & (i_id_rs1 == i_ex_reg_dst);
  assign w_rs2_hit   = i_id_rs2_used & (i_id_rs2 == i_ex_reg_dst);
  assign o_hazard    = w_dst_valid & (w_rs1_hit | w_rs2_hit);

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Central stall/flush controller for the 5-stage pipeline with interrupt entry
// sequencing (RUN -> DRAIN -> INJECT -> ISR). Outputs are combinational from the
// registered FSM state and the current inputs. Optional performance counters are
// built when PIPE_HAZARD_PERF_EN is defined.
module pipe_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int DRAIN_CYCLES = 3
`ifdef PIPE_HAZARD_PERF_EN
  , parameter int CNT_W = PERF_CNT_W
`endif
)(
  input logic               clk,
  input logic               rst_n,
  pipe_hazard_ctrl_if.slave bus
);

  state_e                 r_state;
  state_e                 w_state_nxt;
  logic [DRAIN_CNT_W-1:0] r_drain_cnt;
  logic [DRAIN_CNT_W-1:0] w_drain_cnt_nxt;

  logic w_load_use;
  logic w_pc_stall, w_stall_if_id, w_stall_id_ex, w_stall_ex_mem;
  logic w_flush_if_id, w_flush_id_ex, w_flush_mem_wb;
  logic w_irq_inject, w_irq_ack, w_in_isr;

  load_use_detect u_load_use_detect (
    .i_id_rs1      (bus.id_rs1),
    .i_id_rs2      (bus.id_rs2),
    .i_id_rs1_used (bus.id_rs1_used),
    .i_id_rs2_used (bus.id_rs2_used),
    .i_ex_reg_dst  (bus.ex_reg_dst),
    .i_ex_reg_wr   (bus.ex_reg_wr),
    .i_ex_load     (bus.ex_load),
    .o_hazard      (w_load_use)
  );

  // FSM state and drain counter registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= RUN;
      r_drain_cnt <= {DRAIN_CNT_W{1'b0}};
    end else begin
      r_state     <= w_state_nxt;
      r_drain_cnt <= w_drain_cnt_nxt;
    end
  end

  // Next-state logic; a memory wait freezes the sequencer entirely
  always_comb begin
    w_state_nxt     = r_state;
    w_drain_cnt_nxt = r_drain_cnt;
    if (bus.mem_busy) begin
      w_state_nxt     = r_state;
      w_drain_cnt_nxt = r_drain_cnt;
    end else begin
      case (r_state)
        RUN: begin
          // in_isr is 0 in RUN, so only the redirect can block entry
          if (bus.irq_req && !bus.ex_redirect) begin
            w_state_nxt     = DRAIN;
            w_drain_cnt_nxt = DRAIN_CNT_W'(DRAIN_CYCLES - 1);
          end else begin
            w_state_nxt = RUN;
          end
        end
        DRAIN: begin
          // A redirect aborts so its target becomes the interrupt return point
          if (bus.ex_redirect || !bus.irq_req) begin
            w_state_nxt = RUN;
          end else if (r_drain_cnt == {DRAIN_CNT_W{1'b0}}) begin
            w_state_nxt = INJECT;
          end else begin
            w_drain_cnt_nxt = r_drain_cnt - DRAIN_CNT_W'(1);
          end
        end
        INJECT: begin
          w_state_nxt = ISR;
        end
        ISR: begin
          if (bus.ex_returni) begin
            w_state_nxt = RUN;
          end else begin
            w_state_nxt = ISR;
          end
        end
        default: begin
          w_state_nxt     = RUN;
          w_drain_cnt_nxt = {DRAIN_CNT_W{1'b0}};
        end
      endcase
    end
  end

  // Output logic: memory wait > redirect > drain/load-use
  always_comb begin
    w_pc_stall     = 1'b0;
    w_stall_if_id  = 1'b0;
    w_stall_id_ex  = 1'b0;
    w_stall_ex_mem = 1'b0;
    w_flush_if_id  = 1'b0;
    w_flush_id_ex  = 1'b0;
    w_flush_mem_wb = 1'b0;
    w_irq_inject   = (r_state == INJECT);
    w_irq_ack      = (r_state == INJECT) & ~bus.mem_busy;
    w_in_isr       = (r_state == ISR);
    if (bus.mem_busy) begin
      w_pc_stall     = 1'b1;
      w_stall_if_id  = 1'b1;
      w_stall_id_ex  = 1'b1;
      w_stall_ex_mem = 1'b1;
      w_flush_mem_wb = 1'b1;
    end else if (bus.ex_redirect) begin
      // ID holds a wrong-path instruction, so any load-use is moot
      w_flush_if_id = 1'b1;
      w_flush_id_ex = 1'b1;
    end else if (r_state == DRAIN) begin
      // PC is already held; a load-use only needs its bubble into EX
      w_pc_stall    = 1'b1;
      w_flush_if_id = 1'b1;
      w_flush_id_ex = w_load_use;
    end else if (w_load_use) begin
      w_pc_stall    = 1'b1;
      w_stall_if_id = 1'b1;
      w_flush_id_ex = 1'b1;
    end else begin
      w_pc_stall = 1'b0;
    end
  end

  // All outputs are forced low while reset is asserted
  assign bus.pc_stall     = w_pc_stall     & rst_n;
  assign bus.stall_if_id  = w_stall_if_id  & rst_n;
  assign bus.stall_id_ex  = w_stall_id_ex  & rst_n;
  assign bus.stall_ex_mem = w_stall_ex_mem & rst_n;
  assign bus.flush_if_id  = w_flush_if_id  & rst_n;
  assign bus.flush_id_ex  = w_flush_id_ex  & rst_n;
  assign bus.flush_mem_wb = w_flush_mem_wb & rst_n;
  assign bus.irq_inject   = w_irq_inject   & rst_n;
  assign bus.irq_ack      = w_irq_ack      & rst_n;
  assign bus.in_isr       = w_in_isr       & rst_n;

`ifdef PIPE_HAZARD_PERF_EN
  logic [CNT_W-1:0] r_perf_stall_cnt;
  logic [CNT_W-1:0] r_perf_flush_cnt;
  logic [CNT_W-1:0] r_perf_irq_cnt;

  // Saturating event counters with synchronous clear
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_perf_stall_cnt <= {CNT_W{1'b0}};
      r_perf_flush_cnt <= {CNT_W{1'b0}};
      r_perf_irq_cnt   <= {CNT_W{1'b0}};
    end else if (bus.perf_clr) begin
      r_perf_stall_cnt <= {CNT_W{1'b0}};
      r_perf_flush_cnt <= {CNT_W{1'b0}};
      r_perf_irq_cnt   <= {CNT_W{1'b0}};
    end else begin
      if (w_pc_stall && (r_perf_stall_cnt != {CNT_W{1'b1}})) begin
        r_perf_stall_cnt <= r_perf_stall_cnt + CNT_W'(1);
      end
      if (w_flush_id_ex && (r_perf_flush_cnt != {CNT_W{1'b1}})) begin
        r_perf_flush_cnt <= r_perf_flush_cnt + CNT_W'(1);
      end
      if (w_irq_ack && (r_perf_irq_cnt != {CNT_W{1'b1}})) begin
        r_perf_irq_cnt <= r_perf_irq_cnt + CNT_W'(1);
      end
    end
  end

  assign bus.perf_stall_cnt = r_perf_stall_cnt;
  assign bus.perf_flush_cnt = r_perf_flush_cnt;
  assign bus.perf_irq_cnt   = r_perf_irq_cnt;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed scoreboard bench for pipe_hazard_ctrl (DRAIN_CYCLES = 3).
// Expected output vector bit order:
// {pc_stall, stall_if_id, stall_id_ex, stall_ex_mem, flush_if_id,
//  flush_id_ex, flush_mem_wb, irq_inject, irq_ack, in_isr}
module tb_pipe_hazard_ctrl;

  logic clk;
  logic rst_n;

  pipe_hazard_ctrl_if u_if ();

  pipe_hazard_ctrl #(.DRAIN_CYCLES(3)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (u_if.slave)
  );

  localparam logic [9:0] E_NONE     = 10'b0000000000;
  localparam logic [9:0] E_LU       = 10'b1100010000;
  localparam logic [9:0] E_REDIR    = 10'b0000110000;
  localparam logic [9:0] E_BUSY     = 10'b1111001000;
  localparam logic [9:0] E_DRAIN    = 10'b1000100000;
  localparam logic [9:0] E_INJ      = 10'b0000000110;
  localparam logic [9:0] E_INJ_BUSY = 10'b1111001100;
  localparam logic [9:0] E_ISR      = 10'b0000000001;
  localparam logic [9:0] E_ISR_BUSY = 10'b1111001001;
  localparam logic [9:0] E_ISR_RET  = 10'b0000110001;

  int n_cmp  = 0;
  int n_fail = 0;

  logic [9:0] exp_q[$];
  string      tag_q[$];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic clr_in();
    u_if.id_rs1      = 4'd0;
    u_if.id_rs2      = 4'd0;
    u_if.id_rs1_used = 1'b0;
    u_if.id_rs2_used = 1'b0;
    u_if.ex_reg_dst  = 4'd0;
    u_if.ex_reg_wr   = 1'b0;
    u_if.ex_load     = 1'b0;
    u_if.ex_redirect = 1'b0;
    u_if.ex_returni  = 1'b0;
    u_if.mem_busy    = 1'b0;
    u_if.irq_req     = 1'b0;
`ifdef PIPE_HAZARD_PERF_EN
    u_if.perf_clr    = 1'b0;
`endif
  endtask

  // Load in EX writing dst, ID reading r5 through rs2
  task automatic set_lu(input logic [3:0] dst);
    u_if.ex_load     = 1'b1;
    u_if.ex_reg_wr   = 1'b1;
    u_if.ex_reg_dst  = dst;
    u_if.id_rs2      = 4'd5;
    u_if.id_rs2_used = 1'b1;
  endtask

  // Push expectation, check at the falling edge, return just after the next rising edge
  task automatic step(input logic [9:0] exp, input string tag);
    logic [9:0] obs;
    logic [9:0] e;
    string      t;
    exp_q.push_back(exp);
    tag_q.push_back(tag);
    @(negedge clk);
    obs = {u_if.pc_stall, u_if.stall_if_id, u_if.stall_id_ex, u_if.stall_ex_mem,
           u_if.flush_if_id, u_if.flush_id_ex, u_if.flush_mem_wb,
           u_if.irq_inject, u_if.irq_ack, u_if.in_isr};
    e = exp_q.pop_front();
    t = tag_q.pop_front();
    n_cmp++;
    assert (obs === e) else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b", t, obs, e);
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    clr_in();
    @(posedge clk);
    #1;
    // Reset holds every output low even with a live load-use on the inputs
    set_lu(4'd5);
    step(E_NONE, "reset_gated");
    clr_in();
    step(E_NONE, "reset_idle");
    rst_n = 1'b1;
    step(E_NONE, "run_idle");

    // Load-use through rs2, then one bubble only
    set_lu(4'd5);
    step(E_LU, "lu_rs2");
    clr_in();
    step(E_NONE, "lu_one_cycle");
    set_lu(4'd0);
    u_if.id_rs2 = 4'd0;
    step(E_NONE, "lu_dst_zero");
    set_lu(4'd7);
    u_if.id_rs2 = 4'd7;
    u_if.ex_load = 1'b0;
    step(E_NONE, "lu_not_load");
    clr_in();
    set_lu(4'd9);
    u_if.id_rs2_used = 1'b0;
    u_if.id_rs1 = 4'd9;
    step(E_NONE, "lu_rs1_unused");
    u_if.id_rs1_used = 1'b1;
    step(E_LU, "lu_rs1");

    // Redirect wins over load-use; memory wait wins over both
    u_if.ex_redirect = 1'b1;
    step(E_REDIR, "redir_over_lu");
    u_if.mem_busy = 1'b1;
    step(E_BUSY, "busy_over_all");
    clr_in();

    // Full interrupt entry with DRAIN_CYCLES = 3
    u_if.irq_req = 1'b1;
    step(E_NONE, "irq_run");
    for (int i = 0; i < 3; i++) step(E_DRAIN, $sformatf("irq_drain%0d", i));
    step(E_INJ, "irq_inject");
    step(E_ISR, "irq_isr0");
    step(E_ISR, "irq_nested_ignored");
    u_if.ex_returni = 1'b1;
    u_if.mem_busy   = 1'b1;
    step(E_ISR_BUSY, "isr_ret_busy");
    u_if.mem_busy    = 1'b0;
    u_if.ex_redirect = 1'b1;
    u_if.irq_req     = 1'b0;
    step(E_ISR_RET, "isr_ret");
    clr_in();
    step(E_NONE, "isr_exited");

    // Memory wait during DRAIN freezes the counter at 1
    u_if.irq_req = 1'b1;
    step(E_NONE, "busy_run");
    step(E_DRAIN, "busy_drain_cnt2");
    u_if.mem_busy = 1'b1;
    for (int i = 0; i < 3; i++) step(E_BUSY, $sformatf("busy_frozen%0d", i));
    u_if.mem_busy = 1'b0;
    step(E_DRAIN, "busy_drain_cnt1");
    step(E_DRAIN, "busy_drain_cnt0");
    u_if.mem_busy = 1'b1;
    step(E_INJ_BUSY, "inject_held_no_ack");
    u_if.mem_busy = 1'b0;
    step(E_INJ, "inject_exit_ack");
    step(E_ISR, "busy_isr");
    u_if.ex_returni  = 1'b1;
    u_if.ex_redirect = 1'b1;
    u_if.irq_req     = 1'b0;
    step(E_ISR_RET, "busy_isr_ret");
    clr_in();
    step(E_NONE, "busy_exited");

    // Redirect on the second DRAIN cycle aborts, then re-entry
    u_if.irq_req = 1'b1;
    step(E_NONE, "abort_run");
    step(E_DRAIN, "abort_drain1");
    u_if.ex_redirect = 1'b1;
    step(E_REDIR, "abort_redirect");
    u_if.ex_redirect = 1'b0;
    step(E_NONE, "abort_back_run");
    step(E_DRAIN, "abort_reentry");
    u_if.irq_req = 1'b0;
    step(E_DRAIN, "drop_irq_in_drain");
    step(E_NONE, "drop_back_run");

    // Reset in the middle of DRAIN
    u_if.irq_req = 1'b1;
    step(E_NONE, "rst_run");
    step(E_DRAIN, "rst_drain1");
    rst_n = 1'b0;
    set_lu(4'd5);
    step(E_NONE, "rst_mid_drain");
    clr_in();
    rst_n = 1'b1;
    step(E_NONE, "rst_release_run");
    set_lu(4'd5);
    step(E_LU, "rst_after_lu");
    clr_in();
    u_if.irq_req = 1'b1;
    step(E_NONE, "rst_irq_run");
    for (int i = 0; i < 3; i++) step(E_DRAIN, $sformatf("rst_drain%0d", i));
    step(E_INJ, "rst_inject");
    u_if.irq_req = 1'b0;
    step(E_ISR, "rst_isr");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
